// File: rtl/arch_registers_int_pkg.sv
// Shared definitions for the architectural integer register file:
// default widths and the RISC-V ABI register index names.
package arch_registers_int_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_NUM_REGS = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

  // ABI register indices
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd1;
  localparam reg_idx_t REG_SP   = 5'd2;
  localparam reg_idx_t REG_GP   = 5'd3;
  localparam reg_idx_t REG_TP   = 5'd4;
  localparam reg_idx_t REG_T0   = 5'd5;
  localparam reg_idx_t REG_T1   = 5'd6;
  localparam reg_idx_t REG_T2   = 5'd7;
  localparam reg_idx_t REG_S0   = 5'd8;
  localparam reg_idx_t REG_FP   = 5'd8;
  localparam reg_idx_t REG_S1   = 5'd9;
  localparam reg_idx_t REG_A0   = 5'd10;
  localparam reg_idx_t REG_A1   = 5'd11;
  localparam reg_idx_t REG_A2   = 5'd12;
  localparam reg_idx_t REG_A3   = 5'd13;
  localparam reg_idx_t REG_A4   = 5'd14;
  localparam reg_idx_t REG_A5   = 5'd15;
  localparam reg_idx_t REG_A6   = 5'd16;
  localparam reg_idx_t REG_A7   = 5'd17;
  localparam reg_idx_t REG_S2   = 5'd18;
  localparam reg_idx_t REG_S3   = 5'd19;
  localparam reg_idx_t REG_S4   = 5'd20;
  localparam reg_idx_t REG_S5   = 5'd21;
  localparam reg_idx_t REG_S6   = 5'd22;
  localparam reg_idx_t REG_S7   = 5'd23;
  localparam reg_idx_t REG_S8   = 5'd24;
  localparam reg_idx_t REG_S9   = 5'd25;
  localparam reg_idx_t REG_S10  = 5'd26;
  localparam reg_idx_t REG_S11  = 5'd27;
  localparam reg_idx_t REG_T3   = 5'd28;
  localparam reg_idx_t REG_T4   = 5'd29;
  localparam reg_idx_t REG_T5   = 5'd30;
  localparam reg_idx_t REG_T6   = 5'd31;

endpackage

// File: rtl/arch_reg_read_port.sv
// One combinational read port of the register file: register select with
// enable gating and x0 masking. With ARCH_REG_BYPASS_EN defined, a same-cycle
// write to the addressed register is forwarded straight to the output.
module arch_reg_read_port
  import arch_registers_int_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic [NUM_REGS-1:1][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  logic                            re_i,
  input  logic [ADDR_W-1:0]               waddr_i,
  input  logic                            we_i,
  input  logic [DATA_W-1:0]               wdata_i,
  output logic [DATA_W-1:0]               dout_o
);

  logic [DATA_W-1:0] stored_data;

  // Select the addressed register; index 0 and disabled reads fall through to zero.
  always_comb begin
    // NOTE: default assignment first so every path assigns stored_data (no latch).
    stored_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (re_i && (addr_i == ADDR_W'(i))) stored_data = regs_i[i];
    end
  end

`ifdef ARCH_REG_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = re_i && we_i && (waddr_i != '0) && (waddr_i == addr_i);
  assign dout_o     = bypass_hit ? wdata_i : stored_data;
`else
  // Write-port signals only matter when forwarding is built in.
  logic unused_bypass;

  assign unused_bypass = ^{waddr_i, we_i, wdata_i};
  assign dout_o        = stored_data;
`endif

endmodule

// File: rtl/arch_registers_int.sv
// Architectural integer register file: 32 x 32-bit GPRs, two combinational
// read ports (rs1/rs2) and one synchronous write port (rd). x0 has no storage
// and always reads zero. Optional same-cycle write forwarding is enabled by
// defining ARCH_REG_BYPASS_EN.
module arch_registers_int
  import arch_registers_int_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_p0,
  input  logic              re_p0,
  output logic [DATA_W-1:0] dout_p0,
  input  logic [ADDR_W-1:0] addr_p1,
  input  logic              re_p1,
  output logic [DATA_W-1:0] dout_p1,
  input  logic [ADDR_W-1:0] addr_p2,
  input  logic              we_p2,
  input  logic [DATA_W-1:0] din_p2
);

  // Register flops start at index 1; index 0 holds no state.
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;

  // Next state: only the addressed non-zero register takes the write data.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (we_p2 && (addr_p2 == ADDR_W'(i))) regs_d[i] = din_p2;
    end
  end

  // Register array update with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the array is a flop array, so it can and must be cleared by reset;
    // a RAM macro could not be, and its contents would start undefined.
    if (!reset) begin
      regs_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      regs_q <= regs_d;
    end
  end

  // Read port 0 (rs1)
  arch_reg_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_read_p0 (
    .regs_i  (regs_q),
    .addr_i  (addr_p0),
    .re_i    (re_p0),
    .waddr_i (addr_p2),
    .we_i    (we_p2),
    .wdata_i (din_p2),
    .dout_o  (dout_p0)
  );

  // Read port 1 (rs2)
  arch_reg_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_read_p1 (
    .regs_i  (regs_q),
    .addr_i  (addr_p1),
    .re_i    (re_p1),
    .waddr_i (addr_p2),
    .we_i    (we_p2),
    .wdata_i (din_p2),
    .dout_o  (dout_p1)
  );

endmodule

// File: tb/tb_arch_registers_int.sv
// Self-checking bench for arch_registers_int. A reference array models the
// register file; expected read data is queued when stimulus is applied and
// popped for comparison while the inputs are still held. Honours
// ARCH_REG_BYPASS_EN the same way the design does.
module tb_arch_registers_int;
  import arch_registers_int_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr_p0, addr_p1, addr_p2;
  logic        re_p0, re_p1, we_p2;
  logic [31:0] din_p2;
  logic [31:0] dout_p0, dout_p1;

  always #5 clk = ~clk;

  arch_registers_int dut (
    .clk     (clk),
    .reset   (reset),
    .addr_p0 (addr_p0),
    .re_p0   (re_p0),
    .dout_p0 (dout_p0),
    .addr_p1 (addr_p1),
    .re_p1   (re_p1),
    .dout_p1 (dout_p1),
    .addr_p2 (addr_p2),
    .we_p2   (we_p2),
    .din_p2  (din_p2)
  );

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
    if (!re || a == 5'd0) return 32'h0;
`ifdef ARCH_REG_BYPASS_EN
    if (we_p2 && addr_p2 == a) return din_p2;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Apply one cycle of stimulus after the falling edge and queue the expected reads.
  task automatic drive(input string name, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic r0, input logic [4:0] a0,
                       input logic r1, input logic [4:0] a1);
    exp_t e;
    @(negedge clk);
    we_p2 = we; addr_p2 = wa; din_p2 = wd;
    re_p0 = r0; addr_p0 = a0;
    re_p1 = r1; addr_p1 = a1;
    e.name = name;
    e.d0   = model_read(r0, a0);
    e.d1   = model_read(r1, a1);
    sb.push_back(e);
    #2;
  endtask

  // Let the rising edge commit any pending write into the model.
  task automatic commit();
    @(posedge clk);
    if (reset && we_p2 && addr_p2 != 5'd0) model[addr_p2] = din_p2;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    clear_model();
    drive("reset_hold", 1'b1, REG_T0, 32'hDEAD0001, 1'b1, REG_RA, 1'b1, REG_T0);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    #18;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive("reset_read_all", 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      e = sb.pop_front(); n_cmp++;
      if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
        n_bad++;
        $display("FAIL %s[%0d]: got p0=%h p1=%h, want p0=%h p1=%h", e.name, i, dout_p0, dout_p1, e.d0, e.d1);
      end
      commit();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    drive("wr_ra", 1'b1, REG_RA, 32'hA5A5A5A5, 1'b0, REG_RA, 1'b0, REG_SP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("wr_sp", 1'b1, REG_SP, 32'h5A5A5A5A, 1'b0, REG_RA, 1'b0, REG_SP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("rd_ra_sp", 1'b0, 5'd0, 32'h0, 1'b1, REG_RA, 1'b1, REG_SP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== 32'hA5A5A5A5 || dout_p1 !== 32'h5A5A5A5A || dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
  endtask

  task automatic test_x0_and_enable();
    exp_t e;
    drive("wr_x0", 1'b1, REG_ZERO, 32'hFFFFFFFF, 1'b1, REG_ZERO, 1'b1, REG_ZERO);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("rd_x0", 1'b0, 5'd0, 32'h0, 1'b1, REG_ZERO, 1'b1, REG_ZERO);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== 32'h0 || dout_p1 !== 32'h0) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("re_p0_low", 1'b0, 5'd0, 32'h0, 1'b0, REG_RA, 1'b1, REG_RA);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
  endtask

  task automatic test_same_cycle();
    exp_t e;
    drive("rw_x5_same", 1'b1, REG_T0, 32'h12345678, 1'b1, REG_T0, 1'b1, REG_T0);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("rd_x5_after", 1'b0, 5'd0, 32'h0, 1'b1, REG_T0, 1'b1, REG_T0);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== 32'h12345678 || dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("rw_x6_p0_off", 1'b1, REG_T1, 32'h0BADF00D, 1'b0, REG_T1, 1'b1, REG_T1);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive("both_rd_x2", 1'b0, 5'd0, 32'h0, 1'b1, REG_SP, 1'b1, REG_SP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== 32'h5A5A5A5A || dout_p1 !== 32'h5A5A5A5A) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("wr_x3_rd_x1x2", 1'b1, REG_GP, 32'hDEADBEEF, 1'b1, REG_RA, 1'b1, REG_SP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("wr_x4_a_rd_x3", 1'b1, REG_TP, 32'h11112222, 1'b1, REG_GP, 1'b1, REG_TP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("wr_x4_b_rd_x4", 1'b1, REG_TP, 32'h33334444, 1'b1, REG_TP, 1'b1, REG_RA);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("rd_x4_x3", 1'b0, 5'd0, 32'h0, 1'b1, REG_TP, 1'b1, REG_GP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== 32'h33334444 || dout_p1 !== 32'hDEADBEEF || dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    we_p2 = 1'b1; addr_p2 = REG_T2; din_p2 = 32'hCAFEF00D;
    re_p0 = 1'b1; addr_p0 = REG_RA;
    re_p1 = 1'b1; addr_p1 = REG_SP;
    #2;
    reset = 1'b0;
    clear_model();
    e.name = "async_rst_now";
    e.d0 = model_read(1'b1, REG_RA);
    e.d1 = model_read(1'b1, REG_SP);
    sb.push_back(e);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    @(posedge clk);
    #1;
    e.name = "async_rst_edge";
    e.d0 = model_read(1'b1, REG_RA);
    e.d1 = model_read(1'b1, REG_SP);
    sb.push_back(e);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    @(negedge clk);
    we_p2 = 1'b0;
    reset = 1'b1;
    drive("post_rst_x7_x1", 1'b0, 5'd0, 32'h0, 1'b1, REG_T2, 1'b1, REG_RA);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
    drive("post_rst_x5_x4", 1'b0, 5'd0, 32'h0, 1'b1, REG_T0, 1'b1, REG_TP);
    e = sb.pop_front(); n_cmp++;
    if (dout_p0 !== e.d0 || dout_p1 !== e.d1) begin
      n_bad++;
      $display("FAIL %s: got p0=%h p1=%h, want p0=%h p1=%h", e.name, dout_p0, dout_p1, e.d0, e.d1);
    end
    commit();
  endtask

  // Watchdog: the sequence is a few hundred cycles; never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    we_p2   = 1'b0; addr_p2 = 5'd0; din_p2 = 32'h0;
    re_p0   = 1'b0; addr_p0 = 5'd0;
    re_p1   = 1'b0; addr_p1 = 5'd0;
    test_reset();
    test_write_read();
    test_x0_and_enable();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
